// File: rtl/tia_graphics.sv
// tia_graphics: playfield, sprite and colour-mixing pixel engine with a small
// register file and an optional sticky collision register.
//
// Ports:
//   raw_clk      - sole clock, rising edge
//   reset        - synchronous active-high reset
//   enable       - register read select (read when write_enable is low)
//   address      - 6-bit register address
//   data_in      - 8-bit write data
//   write_enable - register write strobe
//   data_out     - registered read data, holds while enable is low
//   pixel_en     - one-cycle strobe per pixel
//   in_image     - pixel lies inside the visible image
//   pos_x        - pixel column within the image
//   color        - registered pixel colour, two cycles after pixel_en
//
// Configuration macro: TIA_GRAPHICS_COLLISION_EN enables the collision
// register at address 0x20. Without it, 0x20 reads 0 and writes are ignored.
module tia_graphics #(
    parameter int PF_BITS      = 22,
    parameter int PF_SHIFT     = 4,
    parameter int NUM_PLAYERS  = 2,
    parameter int PLAYER_SHIFT = 1
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [5:0] address,
    input  logic [7:0] data_in,
    input  logic       write_enable,
    output logic [7:0] data_out,
    input  logic       pixel_en,
    input  logic       in_image,
    input  logic [9:0] pos_x,
    output logic [6:0] color
);

    localparam logic [23:0] PF_MASK = 24'((64'd1 << PF_BITS) - 64'd1);
    localparam int          SPR_W   = 8 << PLAYER_SHIFT;

    logic [6:0]  color_bg, color_fg;
    logic [1:0]  ctrlpf;
    logic [23:0] playfield;
    logic [7:0]  grp  [4];
    logic [7:0]  xpos [4];
    logic [6:0]  colp [4];
    logic [3:0]  refp;

    logic        player_ok;
    logic [7:0]  rd_value;

    logic [9:0]  pf_idx, pf_rel;
    logic [4:0]  pf_sel;
    logic        pf_hit_c;
    logic [3:0]  p_hit_c;
    logic [6:0]  spr_color_c;

    logic        s1_valid, s1_in_image, s1_pf_hit, s1_prio;
    logic [3:0]  s1_p_hit;
    logic [6:0]  s1_spr, s1_fg, s1_bg;
    logic [6:0]  mix_color;

`ifdef TIA_GRAPHICS_COLLISION_EN
    logic [7:0]  collision;
    logic [7:0]  coll_new;
`endif

    // Per-player registers live in fixed 4-entry arrays; entries at or above
    // NUM_PLAYERS are never written, so they stay zero and read as zero.
    assign player_ok = ({30'b0, address[1:0]} < NUM_PLAYERS);

    // Sprite hit: column offset from the sprite start, no wrap past 1023.
    function automatic logic sprite_hit(input logic [9:0] x, input logic [7:0] xp,
                                        input logic [7:0] g, input logic r);
        logic [9:0] start;
        logic [9:0] offset;
        logic [2:0] b;
        start      = {xp, 2'b00};
        offset     = x - start;
        b          = 3'(offset >> PLAYER_SHIFT);
        sprite_hit = 1'b0;
        if (x >= start && offset < 10'(SPR_W))
            sprite_hit = r ? g[b] : g[3'd7 - b];
    endfunction

    // Register file writes; reset wins over a coincident write.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            color_bg  <= '0;
            color_fg  <= '0;
            ctrlpf    <= '0;
            playfield <= '0;
            refp      <= '0;
            for (int n = 0; n < 4; n++) begin
                grp[n]  <= '0;
                xpos[n] <= '0;
                colp[n] <= '0;
            end
        end else if (write_enable) begin
            case (address)
                6'h00: color_bg <= data_in[7:1];
                6'h01: color_fg <= data_in[7:1];
                6'h02: ctrlpf   <= data_in[1:0];
                6'h03: playfield[23:16] <= data_in & PF_MASK[23:16];
                6'h04: playfield[15:8]  <= data_in & PF_MASK[15:8];
                6'h05: playfield[7:0]   <= data_in & PF_MASK[7:0];
                default: begin
                    if (player_ok) begin
                        case (address[5:2])
                            4'h4: grp[address[1:0]]  <= data_in;
                            4'h5: xpos[address[1:0]] <= data_in;
                            4'h6: colp[address[1:0]] <= data_in[7:1];
                            4'h7: refp[address[1:0]] <= data_in[0];
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Read mux; colour registers return the stored value in its write position.
    always_comb begin
        rd_value = '0;
        case (address)
            6'h00: rd_value = {color_bg, 1'b0};
            6'h01: rd_value = {color_fg, 1'b0};
            6'h02: rd_value = {6'b0, ctrlpf};
            6'h03: rd_value = playfield[23:16];
            6'h04: rd_value = playfield[15:8];
            6'h05: rd_value = playfield[7:0];
`ifdef TIA_GRAPHICS_COLLISION_EN
            6'h20: rd_value = collision;
`endif
            default: begin
                if (player_ok) begin
                    case (address[5:2])
                        4'h4: rd_value = grp[address[1:0]];
                        4'h5: rd_value = xpos[address[1:0]];
                        4'h6: rd_value = {colp[address[1:0]], 1'b0};
                        4'h7: rd_value = {7'b0, refp[address[1:0]]};
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge raw_clk) begin
        if (reset)
            data_out <= '0;
        else if (enable && !write_enable)
            data_out <= rd_value;
    end

    // Playfield lookup: left half is always MSB-first, right half repeats or
    // mirrors depending on the reflect bit.
    always_comb begin
        pf_idx   = pos_x >> PF_SHIFT;
        pf_rel   = pf_idx - 10'(PF_BITS);
        pf_sel   = '0;
        pf_hit_c = 1'b0;
        if (pf_idx < 10'(PF_BITS)) begin
            pf_sel   = 5'(PF_BITS - 1) - pf_idx[4:0];
            pf_hit_c = playfield[pf_sel];
        end else if (pf_rel < 10'(PF_BITS)) begin
            pf_sel   = ctrlpf[0] ? pf_rel[4:0] : 5'(PF_BITS - 1) - pf_rel[4:0];
            pf_hit_c = playfield[pf_sel];
        end
    end

    // Sprite hits and the colour of the lowest-index hitting sprite.
    always_comb begin
        p_hit_c     = '0;
        spr_color_c = '0;
        for (int n = 0; n < 4; n++)
            p_hit_c[n] = (n < NUM_PLAYERS) && sprite_hit(pos_x, xpos[n], grp[n], refp[n]);
        for (int n = 3; n >= 0; n--)
            if (p_hit_c[n]) spr_color_c = colp[n];
    end

    // Stage 1 snapshots the colour registers along with the hits so that a
    // write landing between the two stages cannot alter an in-flight pixel.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_in_image <= 1'b0;
            s1_pf_hit   <= 1'b0;
            s1_p_hit    <= '0;
            s1_prio     <= 1'b0;
            s1_spr      <= '0;
            s1_fg       <= '0;
            s1_bg       <= '0;
        end else begin
            s1_valid <= pixel_en;
            if (pixel_en) begin
                s1_in_image <= in_image;
                s1_pf_hit   <= pf_hit_c;
                s1_p_hit    <= p_hit_c;
                s1_prio     <= ctrlpf[1];
                s1_spr      <= spr_color_c;
                s1_fg       <= color_fg;
                s1_bg       <= color_bg;
            end
        end
    end

    always_comb begin
        if (s1_prio)
            mix_color = s1_pf_hit ? s1_fg : (|s1_p_hit) ? s1_spr : s1_bg;
        else
            mix_color = (|s1_p_hit) ? s1_spr : s1_pf_hit ? s1_fg : s1_bg;
    end

    // Stage 2: colour output, blanked outside the visible image.
    always_ff @(posedge raw_clk) begin
        if (reset)
            color <= '0;
        else if (s1_valid)
            color <= s1_in_image ? mix_color : 7'd0;
    end

`ifdef TIA_GRAPHICS_COLLISION_EN
    always_comb begin
        coll_new = '0;
        for (int n = 0; n < 4; n++) begin
            coll_new[n]     = s1_p_hit[n] & s1_pf_hit;
            coll_new[4 + n] = s1_p_hit[n] & (|(s1_p_hit & ~(4'b0001 << n)));
        end
    end

    // Sticky collision bits; a clear on the same edge discards new hits.
    always_ff @(posedge raw_clk) begin
        if (reset)
            collision <= '0;
        else if (write_enable && address == 6'h20)
            collision <= '0;
        else if (s1_valid && s1_in_image)
            collision <= collision | coll_new;
    end
`endif

endmodule
